// File: rtl/l1_bus_arbiter_pkg.sv
// Shared types and width helpers for the L1 snooping-bus arbiter.
// Bus ownership walks IDLE -> GRANT -> HOLD -> RELEASE and back to IDLE.
package l1_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StHold    = 2'd2,
        StRelease = 2'd3
    } arb_state_e;

    // Ceiling log2; log2c(1) == 0.
    function automatic int unsigned log2c(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned offset_width(input int unsigned max_offset_bits);
        return log2c(max_offset_bits) + 1;
    endfunction

    function automatic int unsigned id_width(input int unsigned num_caches);
        return (num_caches > 1) ? log2c(num_caches) : 1;
    endfunction

endpackage

// File: rtl/l1_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr_i,
// wrapping modulo N.
module l1_bus_arbiter_rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           found_o,
    output logic [IDW-1:0] idx_o
);

    always_comb begin
        int unsigned j;
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!found_o && req_i[j]) begin
                found_o = 1'b1;
                idx_o   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/l1_bus_arbiter.sv
// Round-robin owner of the shared snooping bus: one L1 cache at a time, sequenced
// through grant/setup, hold and a one-cycle release, with a hold watchdog.
module l1_bus_arbiter
    import l1_bus_arbiter_pkg::*;
#(
    parameter int unsigned  NUM_CACHES      = 4,
    parameter int unsigned  MAX_OFFSET_BITS = 3,
    parameter int unsigned  MAX_HOLD        = 256,
    localparam int unsigned OFFSET_W        = offset_width(MAX_OFFSET_BITS),
    localparam int unsigned ID_BITS         = id_width(NUM_CACHES)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_CACHES-1:0]          bus_request,
    input  logic [NUM_CACHES*OFFSET_W-1:0] active_offset,
    output logic [NUM_CACHES-1:0]          bus_master,
    output logic                           req_ready,
    output logic [OFFSET_W-1:0]            curr_offset,
    output logic [ID_BITS-1:0]             master_id,
    output logic                           bus_busy,
    output logic                           hold_timeout
);

    localparam int unsigned HoldW = log2c(MAX_HOLD) + 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(MAX_HOLD - 1);

    arb_state_e            state_q, state_d;
    logic [ID_BITS-1:0]    idx_q, idx_d;
    logic [ID_BITS-1:0]    ptr_q, ptr_d;
    logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [NUM_CACHES-1:0] bus_master_q, bus_master_d;
    logic                  req_ready_q, req_ready_d;
    logic                  timeout_q, timeout_d;

    logic               pick_found;
    logic [ID_BITS-1:0] pick_idx;
    logic [OFFSET_W-1:0] offs [NUM_CACHES];

    l1_bus_arbiter_rr_pick #(
        .N   (NUM_CACHES),
        .IDW (ID_BITS)
    ) u_rr_pick (
        .req_i   (bus_request),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_CACHES; i++) begin
            offs[i] = active_offset[i*OFFSET_W +: OFFSET_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        hold_cnt_d   = hold_cnt_q;
        bus_master_d = bus_master_q;
        req_ready_d  = 1'b0;
        timeout_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus_master_d = '0;
                hold_cnt_d   = '0;
                if (pick_found) begin
                    idx_d        = pick_idx;
                    bus_master_d = NUM_CACHES'(1) << pick_idx;
                    state_d      = StGrant;
                end
            end
            StGrant: begin
                if (bus_request[idx_q]) begin
                    req_ready_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    bus_master_d = '0;
                    state_d      = StRelease;
                end
            end
            StHold: begin
                // A falling request wins over the watchdog: normal release, no pulse.
                if (!bus_request[idx_q]) begin
                    bus_master_d = '0;
                    state_d      = StRelease;
                end else if (hold_cnt_q == HoldLast) begin
                    bus_master_d = '0;
                    timeout_d    = 1'b1;
                    state_d      = StRelease;
                end else begin
                    req_ready_d = 1'b1;
                    if (hold_cnt_q != '1) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            StRelease: begin
                bus_master_d = '0;
                hold_cnt_d   = '0;
                ptr_d        = (32'(idx_q) == NUM_CACHES - 1) ? '0 : idx_q + 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            ptr_q        <= '0;
            hold_cnt_q   <= '0;
            bus_master_q <= '0;
            req_ready_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            bus_master_q <= bus_master_d;
            req_ready_q  <= req_ready_d;
            timeout_q    <= timeout_d;
        end
    end

    logic owned;
    assign owned = (state_q == StGrant) || (state_q == StHold);

    assign bus_master   = bus_master_q;
    assign req_ready    = req_ready_q;
    assign hold_timeout = timeout_q;
    assign bus_busy     = (state_q != StIdle);
    assign curr_offset  = owned ? offs[idx_q] : '0;
    assign master_id    = owned ? idx_q : '0;

endmodule

// File: tb/tb_l1_bus_arbiter.sv
// Randomised and directed bench for l1_bus_arbiter against a cycle-level ownership model.
module tb_l1_bus_arbiter;

    localparam int N  = 4;
    localparam int OW = l1_bus_arbiter_pkg::offset_width(3);
    localparam int IW = 2;
    localparam int MH = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    bus_request;
    logic [N*OW-1:0] active_offset;
    logic [N-1:0]    bus_master;
    logic            req_ready;
    logic [OW-1:0]   curr_offset;
    logic [IW-1:0]   master_id;
    logic            bus_busy;
    logic            hold_timeout;

    always #5 clock = ~clock;

    l1_bus_arbiter #(
        .NUM_CACHES      (N),
        .MAX_OFFSET_BITS (3),
        .MAX_HOLD        (MH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .bus_request   (bus_request),
        .active_offset (active_offset),
        .bus_master    (bus_master),
        .req_ready     (req_ready),
        .curr_offset   (curr_offset),
        .master_id     (master_id),
        .bus_busy      (bus_busy),
        .hold_timeout  (hold_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner = cache holding the bus (-1 none); age = cycles since grant;
    // cool = in the post-release dead cycle; pulse = forced release just happened.
    int owner = -1;
    int age   = 0;
    int ptr   = 0;
    bit cool  = 0;
    bit pulse = 0;
    int n_pulses = 0;

    int grants[$];
    logic [N-1:0] prev_bm = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_req(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [N-1:0] r);
        pulse = 0;
        if (rst) begin
            owner = -1; age = 0; cool = 0; ptr = 0;
        end else if (owner >= 0) begin
            if (!r[owner] || age == MH) begin
                pulse = r[owner];
                ptr   = (owner + 1) % N;
                owner = -1;
                cool  = 1;
            end else begin
                age++;
            end
        end else if (cool) begin
            cool = 0;
        end else begin
            owner = first_req(r, ptr);
            age   = 0;
        end
    endtask

    task automatic tick(input logic rst, input logic [N-1:0] r, input logic [N*OW-1:0] off,
                        input string tag);
        logic [N-1:0]  e_bm;
        logic [OW-1:0] e_off;
        @(negedge clock);
        reset = rst; bus_request = r; active_offset = off;
        @(posedge clock);
        model_step(rst, r);
        #1;
        e_bm  = (owner >= 0) ? (N'(1) << owner) : '0;
        e_off = (owner >= 0) ? off[owner*OW +: OW] : '0;
        check_eq({tag, ".bus_master"}, 32'(bus_master), 32'(e_bm));
        check_eq({tag, ".req_ready"}, 32'(req_ready), 32'(owner >= 0 && age >= 1));
        check_eq({tag, ".curr_offset"}, 32'(curr_offset), 32'(e_off));
        check_eq({tag, ".master_id"}, 32'(master_id), (owner >= 0) ? owner : 0);
        check_eq({tag, ".bus_busy"}, 32'(bus_busy), 32'(owner >= 0 || cool));
        check_eq({tag, ".hold_timeout"}, 32'(hold_timeout), 32'(pulse));
        if (hold_timeout === 1'b1) n_pulses++;
        if (bus_master != '0 && prev_bm == '0) begin
            for (int i = 0; i < N; i++) if (bus_master[i]) grants.push_back(i);
        end
        prev_bm = bus_master;
    endtask

    function automatic logic [N*OW-1:0] pack_off(input int o0, input int o1, input int o2,
                                                  input int o3);
        logic [N*OW-1:0] v;
        v = '0;
        v[0*OW +: OW] = OW'(o0);
        v[1*OW +: OW] = OW'(o1);
        v[2*OW +: OW] = OW'(o2);
        v[3*OW +: OW] = OW'(o3);
        return v;
    endfunction

    logic [N*OW-1:0] offs;
    logic [N-1:0]    rq;
    int              exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset = 1'b1; bus_request = '0; active_offset = '0;
        offs = pack_off(2, 3, 2, 2);

        // Reset with everyone requesting, then first grant.
        tick(1, 4'hF, offs, "rst");
        tick(1, 4'hF, offs, "rst");
        for (int i = 0; i < 4; i++) tick(0, 4'hF, offs, "first");
        for (int i = 0; i < 6; i++) tick(0, 4'h0, offs, "drain");

        // Single requester timeline.
        tick(1, 4'h0, offs, "rst2");
        for (int i = 0; i < 6; i++) tick(0, 4'b0100, offs, "single");
        for (int i = 0; i < 4; i++) tick(0, 4'b0000, offs, "single_off");

        // All requesting, each master drops after three HOLD cycles.
        tick(1, 4'h0, offs, "rst3");
        grants.delete();
        for (int i = 0; i < 34; i++) begin
            rq = 4'hF;
            if (owner >= 0 && age >= 3) rq[owner] = 1'b0;
            tick(0, rq, offs, "rr");
        end
        check_eq("rr.grant_count_ok", 32'(grants.size() >= 5), 32'd1);
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            check_eq($sformatf("rr.order%0d", i), grants[i], exp_order[i]);
        end

        // Offset mux for master 1.
        tick(1, 4'h0, offs, "rst4");
        for (int i = 0; i < 5; i++) tick(0, 4'b0010, offs, "offset");
        for (int i = 0; i < 4; i++) tick(0, 4'b0000, offs, "offset_off");

        // Watchdog: cache 0 never lets go, cache 2 waiting.
        tick(1, 4'h0, offs, "rst5");
        n_pulses = 0;
        grants.delete();
        for (int i = 0; i < 16; i++) tick(0, 4'b0101, offs, "watchdog");
        check_eq("watchdog.pulses", 32'(n_pulses), 32'd1);
        check_eq("watchdog.next_grant", (grants.size() >= 2) ? grants[1] : -1, 2);
        // Request falls exactly at the limit: no pulse.
        for (int i = 0; i < 6; i++) tick(0, 4'h0, offs, "wd_idle");
        n_pulses = 0;
        for (int i = 0; i < 9; i++) tick(0, 4'b0001, offs, "wd_edge");
        tick(0, 4'b0000, offs, "wd_edge");
        tick(0, 4'b0000, offs, "wd_edge");
        check_eq("wd_edge.pulses", 32'(n_pulses), 32'd0);

        // Reset while cache 3 is holding.
        tick(1, 4'h0, offs, "rst6");
        for (int i = 0; i < 4; i++) tick(0, 4'b1000, offs, "hold3");
        tick(1, 4'b1010, offs, "midrst");
        grants.delete();
        for (int i = 0; i < 4; i++) tick(0, 4'b1010, offs, "after_rst");
        check_eq("after_rst.grant", (grants.size() >= 1) ? grants[0] : -1, 1);

        // Random traffic with sticky requests and rare resets.
        rq = '0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) rq[b] = ~rq[b];
            offs = N*OW'($urandom);
            tick(($urandom_range(99) == 0), rq, offs, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
